jtag_work_bridge: RTL and testbench

- Protocol engine in the rx_clk domain, between the JTAG FIFO pair and the hashing core.
- Pops 9-bit host words from the host-to-device FIFO and assembles LOAD_WORK commands into a 256-bit midstate and 96-bit data word for the core.
- Queues golden nonces from the core and serialises them, and status replies, as 12-bit words into the device-to-host FIFO.

---
 rtl/jtag_work_bridge_if.sv | 33 +++
 rtl/jtag_work_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_jtag_work_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_work_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_work_bridge_if
//  Description : Bundle of the host FIFO, device FIFO, work and nonce signals
//                that surround jtag_work_bridge.
//  Revision    : 1.0  initial release
// ============================================================================
interface jtag_work_bridge_if;
  logic [8:0]   h2d_data;
  logic         h2d_empty;
  logic         h2d_rd_en;
  logic [11:0]  d2h_data;
  logic         d2h_wr_en;
  logic         d2h_full;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic         work_valid;
  logic [31:0]  golden_nonce;
  logic         golden_nonce_valid;

  // Bridge side
  modport master (
    input  h2d_data, h2d_empty, d2h_full, golden_nonce, golden_nonce_valid,
    output h2d_rd_en, d2h_data, d2h_wr_en, midstate, data, work_valid
  );

  // FIFO pair and hashing core side
  modport slave (
    output h2d_data, h2d_empty, d2h_full, golden_nonce, golden_nonce_valid,
    input  h2d_rd_en, d2h_data, d2h_wr_en, midstate, data, work_valid
  );
endinterface
`default_nettype wire

// File: rtl/jtag_work_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_work_bridge
//  Description : Parses host LOAD_WORK/flush/status commands into work for the
//                core and serialises golden nonces and status to the host.
//  Revision    : 1.0  initial release
// ============================================================================
module jtag_work_bridge #(
  parameter int NONCE_DEPTH = 4
) (
  input  wire logic           rx_clk,
  input  wire logic           jt_reset,
  jtag_work_bridge_if.master  bus
);

  localparam int c_PTR_W = (NONCE_DEPTH > 1) ? $clog2(NONCE_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [5:0] c_LAST_BYTE = 6'd43;

  typedef enum logic [0:0] {
    P_IDLE = 1'b0,
    P_LOAD = 1'b1
  } parse_state_t;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_NONCE  = 2'd1,
    T_STATUS = 2'd2
  } tx_state_t;

  // --------------------------------------------------------------------------
  // Host FIFO read side (non-FWFT: word valid the cycle after the pop)
  // --------------------------------------------------------------------------
  logic       r_rd_pending;
  logic       w_rd_en;
  logic       w_word_valid;
  logic       w_is_cmd;
  logic [7:0] w_byte;
  logic       w_cmd_load;
  logic       w_cmd_flush;
  logic       w_cmd_status;

  assign w_rd_en        = !jt_reset && !bus.h2d_empty && !r_rd_pending;
  assign bus.h2d_rd_en  = w_rd_en;

  always_ff @(posedge rx_clk or posedge jt_reset) begin
    if (jt_reset) begin
      r_rd_pending <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_en;
    end
  end

  assign w_word_valid = r_rd_pending;
  assign w_is_cmd     = bus.h2d_data[8];
  assign w_byte       = bus.h2d_data[7:0];

  // Commands are decoded identically in both parser states, which gives resync
  assign w_cmd_load   = w_word_valid && w_is_cmd && (w_byte == 8'h01);
  assign w_cmd_flush  = w_word_valid && w_is_cmd && (w_byte == 8'h02);
  assign w_cmd_status = w_word_valid && w_is_cmd && (w_byte == 8'h03);

  // --------------------------------------------------------------------------
  // Parser: collects 44 bytes into a shadow, commits atomically
  // --------------------------------------------------------------------------
  parse_state_t r_pstate;
  logic [5:0]   r_k;
  logic [351:0] r_shadow;
  logic [255:0] r_midstate;
  logic [95:0]  r_data;
  logic         r_work_valid;

  always_ff @(posedge rx_clk or posedge jt_reset) begin
    if (jt_reset) begin
      r_pstate     <= P_IDLE;
      r_k          <= 6'd0;
      r_shadow     <= '0;
      r_midstate   <= '0;
      r_data       <= '0;
      r_work_valid <= 1'b0;
    end else begin
      r_work_valid <= 1'b0;
      if (w_word_valid) begin
        if (w_is_cmd) begin
          r_pstate <= w_cmd_load ? P_LOAD : P_IDLE;
          r_k      <= 6'd0;
        end else if (r_pstate == P_LOAD) begin
          r_shadow[{r_k, 3'b000} +: 8] <= w_byte;
          if (r_k == c_LAST_BYTE) begin
            // Final byte bypasses the shadow so the commit lands on this edge
            r_midstate   <= r_shadow[255:0];
            r_data       <= {w_byte, r_shadow[343:256]};
            r_work_valid <= 1'b1;
            r_pstate     <= P_IDLE;
            r_k          <= 6'd0;
          end else begin
            r_k <= r_k + 6'd1;
          end
        end
      end
    end
  end

  assign bus.midstate   = r_midstate;
  assign bus.data       = r_data;
  assign bus.work_valid = r_work_valid;

  // --------------------------------------------------------------------------
  // Golden-nonce circular queue
  // --------------------------------------------------------------------------
  logic [31:0]        r_mem [NONCE_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               w_q_full;
  logic               w_enq;
  logic               w_deq;

  assign w_q_full = (r_count == c_CNT_W'(NONCE_DEPTH));
  assign w_enq    = bus.golden_nonce_valid && !w_q_full && !w_cmd_flush;

  always_ff @(posedge rx_clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= bus.golden_nonce;
    end
  end

  always_ff @(posedge rx_clk or posedge jt_reset) begin
    if (jt_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_cmd_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.golden_nonce_valid && w_q_full) begin
        r_overflow <= 1'b1;
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX serialiser
  // --------------------------------------------------------------------------
  tx_state_t   r_tstate;
  logic [1:0]  r_idx;
  logic [31:0] r_shift;
  logic [11:0] r_word;
  logic        r_pop_ok;
  logic        r_status_pending;
  logic        w_tx_push;
  logic [4:0]  w_cnt_ext;
  logic [2:0]  w_cnt_sat;
  logic [11:0] w_status_word;
  logic [31:0] w_head;

  assign w_head        = r_mem[r_rd_ptr];
  assign w_cnt_ext     = 5'(r_count);
  assign w_cnt_sat     = (w_cnt_ext > 5'd7) ? 3'd7 : w_cnt_ext[2:0];
  assign w_status_word = {4'b0100, r_overflow, w_cnt_sat, 4'b0000};

  // Gating the strobe with the live full flag keeps pushes off a full FIFO
  assign w_tx_push     = (r_tstate != T_IDLE) && !bus.d2h_full;
  assign w_deq         = (r_tstate == T_NONCE) && w_tx_push && (r_idx == 2'd3)
                         && r_pop_ok && (r_count != '0);

  always_ff @(posedge rx_clk or posedge jt_reset) begin
    if (jt_reset) begin
      r_tstate         <= T_IDLE;
      r_idx            <= 2'd0;
      r_shift          <= '0;
      r_word           <= '0;
      r_pop_ok         <= 1'b0;
      r_status_pending <= 1'b0;
    end else begin
      if (w_cmd_status) begin
        r_status_pending <= 1'b1;
      end else if ((r_tstate == T_STATUS) && w_tx_push) begin
        r_status_pending <= 1'b0;
      end
      // A flush mid-nonce lets the latched entry finish but must not pop
      if (w_cmd_flush) begin
        r_pop_ok <= 1'b0;
      end

      case (r_tstate)
        T_IDLE: begin
          if (!bus.d2h_full) begin
            if (r_status_pending) begin
              r_word   <= w_status_word;
              r_tstate <= T_STATUS;
            end else if (r_count != '0) begin
              r_shift  <= w_head;
              r_word   <= {2'b10, 2'b00, w_head[7:0]};
              r_idx    <= 2'd0;
              r_pop_ok <= !w_cmd_flush;
              r_tstate <= T_NONCE;
            end
          end
        end
        T_NONCE: begin
          if (w_tx_push) begin
            if (r_idx == 2'd3) begin
              r_tstate <= T_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_word  <= {2'b10, r_idx + 2'd1, r_shift[15:8]};
              r_shift <= {8'h00, r_shift[31:8]};
            end
          end
        end
        T_STATUS: begin
          if (w_tx_push) begin
            r_tstate <= T_IDLE;
          end
        end
        default: r_tstate <= T_IDLE;
      endcase
    end
  end

  assign bus.d2h_data  = r_word;
  assign bus.d2h_wr_en = w_tx_push;

endmodule
`default_nettype wire

// File: tb/tb_jtag_work_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_work_bridge
//  Description : Self-checking bench for jtag_work_bridge with FIFO models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jtag_work_bridge;

  logic rx_clk   = 1'b0;
  logic jt_reset = 1'b1;

  jtag_work_bridge_if bus ();

  jtag_work_bridge #(.NONCE_DEPTH(4)) dut (
    .rx_clk   (rx_clk),
    .jt_reset (jt_reset),
    .bus      (bus)
  );

  always #5 rx_clk = ~rx_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]   h2d_q [$];
  logic [11:0]  got_d2h [$];
  logic [351:0] got_work [$];
  int pops     = 0;
  int rd_viol  = 0;
  int wr_viol  = 0;
  int wv_cyc   = 0;
  logic [351:0] exp_work = '0;

  // Host-to-device FIFO model: pop at the edge, data presented next cycle
  always @(posedge rx_clk) begin
    if (bus.h2d_rd_en) begin
      if (bus.h2d_empty || h2d_q.size() == 0) rd_viol <= rd_viol + 1;
      else begin
        bus.h2d_data <= h2d_q.pop_front();
        pops <= pops + 1;
      end
    end
  end

  always @(negedge rx_clk) begin
    bus.h2d_empty <= (h2d_q.size() == 0);
    if (bus.d2h_wr_en) begin
      got_d2h.push_back(bus.d2h_data);
      if (bus.d2h_full) wr_viol <= wr_viol + 1;
    end
    if (bus.work_valid) begin
      wv_cyc <= wv_cyc + 1;
      got_work.push_back({bus.data, bus.midstate});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic wait_d2h(input int n, input int budget);
    for (int c = 0; c < budget && got_d2h.size() < n; c++) tick(1);
  endtask

  task automatic pulse_nonce(input logic [31:0] n);
    bus.golden_nonce       = n;
    bus.golden_nonce_valid = 1'b1;
    tick(1);
    bus.golden_nonce_valid = 1'b0;
  endtask

  function automatic logic [11:0] nonce_word(input logic [31:0] n, input int i);
    logic [1:0] ii;
    ii = 2'(i);
    return {2'b10, ii, 8'(n >> (8 * i))};
  endfunction

  // Host-word stream interpreter: returns every {data, midstate} a stream commits
  task automatic model_loads(input logic [8:0] words [$], output logic [351:0] commits [$]);
    logic [7:0] buf_q [$];
    logic       loading;
    logic [351:0] v;
    loading = 1'b0;
    commits = {};
    foreach (words[w]) begin
      if (words[w][8]) begin
        loading = (words[w][7:0] == 8'h01);
        buf_q = {};
      end else if (loading) begin
        buf_q.push_back(words[w][7:0]);
        if (buf_q.size() == 44) begin
          for (int j = 0; j < 44; j++) v[8*j +: 8] = buf_q[j];
          commits.push_back(v);
          loading = 1'b0;
          buf_q = {};
        end
      end
    end
  endtask

  task automatic test_reset();
    h2d_q.push_back(9'h0AA);
    jt_reset = 1'b1;
    tick(3);
    n_checks++; if (bus.h2d_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", bus.h2d_rd_en); else n_pass++;
    n_checks++; if (bus.d2h_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", bus.d2h_wr_en); else n_pass++;
    n_checks++; if (bus.d2h_data !== 12'h000) $display("FAIL reset_d2h_data: got %h expected 000", bus.d2h_data); else n_pass++;
    n_checks++; if (bus.midstate !== 256'h0) $display("FAIL reset_midstate: got %h expected 0", bus.midstate); else n_pass++;
    n_checks++; if (bus.data !== 96'h0) $display("FAIL reset_data: got %h expected 0", bus.data); else n_pass++;
    n_checks++; if (bus.work_valid !== 1'b0) $display("FAIL reset_work_valid: got %b expected 0", bus.work_valid); else n_pass++;
    jt_reset = 1'b0;
    tick(10);
  endtask

  task automatic test_load_commit();
    int wv0, wb, rv0;
    wv0 = wv_cyc; wb = got_work.size(); rv0 = rd_viol;
    h2d_q.push_back(9'h101);
    for (int j = 0; j < 44; j++) begin
      h2d_q.push_back(9'(j));
      exp_work[8*j +: 8] = 8'(j);
    end
    for (int c = 0; c < 300 && got_work.size() == wb; c++) tick(1);
    tick(5);
    n_checks++; if (wv_cyc - wv0 !== 1) $display("FAIL load_wv_pulse: got %0d cycles expected 1", wv_cyc - wv0); else n_pass++;
    n_checks++; if (bus.midstate[7:0] !== 8'h00) $display("FAIL load_ms_lo: got %h expected 00", bus.midstate[7:0]); else n_pass++;
    n_checks++; if (bus.midstate[255:248] !== 8'h1F) $display("FAIL load_ms_hi: got %h expected 1f", bus.midstate[255:248]); else n_pass++;
    n_checks++; if (bus.data[95:88] !== 8'h2B) $display("FAIL load_data_hi: got %h expected 2b", bus.data[95:88]); else n_pass++;
    n_checks++; if ({bus.data, bus.midstate} !== exp_work) $display("FAIL load_full: got %h expected %h", {bus.data, bus.midstate}, exp_work); else n_pass++;
    n_checks++; if (rd_viol - rv0 !== 0) $display("FAIL load_rd_while_empty: got %0d expected 0", rd_viol - rv0); else n_pass++;
  endtask

  task automatic test_abort_status();
    int wv0, b;
    wv0 = wv_cyc; b = got_d2h.size();
    h2d_q.push_back(9'h101);
    for (int j = 0; j < 20; j++) h2d_q.push_back(9'($urandom_range(0, 255)));
    h2d_q.push_back(9'h103);
    wait_d2h(b + 1, 300);
    tick(5);
    n_checks++; if (wv_cyc - wv0 !== 0) $display("FAIL abort_wv: got %0d expected 0", wv_cyc - wv0); else n_pass++;
    n_checks++; if ({bus.data, bus.midstate} !== exp_work) $display("FAIL abort_keep_work: got %h expected %h", {bus.data, bus.midstate}, exp_work); else n_pass++;
    n_checks++; if (got_d2h.size() - b !== 1) $display("FAIL abort_status_count: got %0d expected 1", got_d2h.size() - b); else n_pass++;
    if (got_d2h.size() > b) begin
      n_checks++; if (got_d2h[b] !== 12'h400) $display("FAIL abort_status_word: got %h expected 400", got_d2h[b]); else n_pass++;
    end
  endtask

  task automatic test_nonce_stream();
    logic [11:0] exp [4];
    int b;
    exp = '{12'h8EF, 12'h9BE, 12'hAAD, 12'hBDE};
    b = got_d2h.size();
    pulse_nonce(32'hDEADBEEF);
    wait_d2h(b + 4, 100);
    tick(5);
    n_checks++; if (got_d2h.size() - b !== 4) $display("FAIL nonce_count: got %0d expected 4", got_d2h.size() - b); else n_pass++;
    for (int i = 0; i < 4; i++) if (got_d2h.size() > b + i) begin
      n_checks++; if (got_d2h[b+i] !== exp[i]) $display("FAIL nonce_byte%0d: got %h expected %h", i, got_d2h[b+i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp [4];
    int b, s, wv0;
    exp = '{12'h8EF, 12'h9BE, 12'hAAD, 12'hBDE};
    b = got_d2h.size(); wv0 = wr_viol;
    pulse_nonce(32'hDEADBEEF);
    for (int c = 0; c < 100 && got_d2h.size() < b + 2; c++) tick(1);
    bus.d2h_full = 1'b1;
    s = got_d2h.size();
    tick(5);
    n_checks++; if (got_d2h.size() !== s) $display("FAIL bp_push_while_full: got %0d words expected %0d", got_d2h.size(), s); else n_pass++;
    bus.d2h_full = 1'b0;
    wait_d2h(b + 4, 100);
    tick(5);
    n_checks++; if (got_d2h.size() - b !== 4) $display("FAIL bp_count: got %0d expected 4", got_d2h.size() - b); else n_pass++;
    for (int i = 0; i < 4; i++) if (got_d2h.size() > b + i) begin
      n_checks++; if (got_d2h[b+i] !== exp[i]) $display("FAIL bp_byte%0d: got %h expected %h", i, got_d2h[b+i], exp[i]); else n_pass++;
    end
    n_checks++; if (wr_viol - wv0 !== 0) $display("FAIL bp_wr_while_full: got %0d expected 0", wr_viol - wv0); else n_pass++;
  endtask

  task automatic test_overflow_flush();
    logic [31:0] n [5];
    logic [11:0] e;
    int b, k;
    b = got_d2h.size();
    bus.d2h_full = 1'b1;
    for (int i = 0; i < 5; i++) n[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      bus.golden_nonce = n[i];
      bus.golden_nonce_valid = 1'b1;
      tick(1);
    end
    bus.golden_nonce_valid = 1'b0;
    h2d_q.push_back(9'h103);
    tick(10);
    bus.d2h_full = 1'b0;
    wait_d2h(b + 17, 200);
    tick(10);
    n_checks++; if (got_d2h.size() - b !== 17) $display("FAIL ovf_count: got %0d expected 17", got_d2h.size() - b); else n_pass++;
    if (got_d2h.size() > b) begin
      n_checks++; if (got_d2h[b] !== 12'h4C0) $display("FAIL ovf_status: got %h expected 4c0", got_d2h[b]); else n_pass++;
    end
    k = b + 1;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      e = nonce_word(n[i], j);
      if (got_d2h.size() > k) begin
        n_checks++; if (got_d2h[k] !== e) $display("FAIL ovf_nonce%0d_b%0d: got %h expected %h", i, j, got_d2h[k], e); else n_pass++;
      end
      k++;
    end
    b = got_d2h.size();
    h2d_q.push_back(9'h102);
    h2d_q.push_back(9'h103);
    wait_d2h(b + 1, 100);
    tick(5);
    n_checks++; if (got_d2h.size() - b !== 1) $display("FAIL flush_count: got %0d expected 1", got_d2h.size() - b); else n_pass++;
    if (got_d2h.size() > b) begin
      n_checks++; if (got_d2h[b] !== 12'h400) $display("FAIL flush_status: got %h expected 400", got_d2h[b]); else n_pass++;
    end
  endtask

  task automatic test_reset_midway();
    int p0, wv0, b;
    p0 = pops; wv0 = wv_cyc;
    h2d_q.push_back(9'h101);
    for (int j = 0; j < 44; j++) h2d_q.push_back(9'($urandom_range(0, 255)));
    for (int c = 0; c < 200 && pops - p0 < 31; c++) tick(1);
    jt_reset = 1'b1;
    #1;
    n_checks++; if (bus.midstate !== 256'h0) $display("FAIL rst_load_midstate: got %h expected 0", bus.midstate); else n_pass++;
    n_checks++; if (bus.data !== 96'h0) $display("FAIL rst_load_data: got %h expected 0", bus.data); else n_pass++;
    n_checks++; if (bus.h2d_rd_en !== 1'b0) $display("FAIL rst_load_rd_en: got %b expected 0", bus.h2d_rd_en); else n_pass++;
    tick(2);
    jt_reset = 1'b0;
    tick(60);
    n_checks++; if (wv_cyc - wv0 !== 0) $display("FAIL rst_load_wv: got %0d expected 0", wv_cyc - wv0); else n_pass++;
    n_checks++; if (bus.midstate !== 256'h0) $display("FAIL rst_load_no_commit: got %h expected 0", bus.midstate); else n_pass++;

    b = got_d2h.size();
    pulse_nonce($urandom);
    for (int c = 0; c < 100 && got_d2h.size() < b + 2; c++) tick(1);
    jt_reset = 1'b1;
    #1;
    n_checks++; if (bus.d2h_wr_en !== 1'b0) $display("FAIL rst_nonce_wr_en: got %b expected 0", bus.d2h_wr_en); else n_pass++;
    n_checks++; if (bus.d2h_data !== 12'h000) $display("FAIL rst_nonce_data: got %h expected 000", bus.d2h_data); else n_pass++;
    tick(2);
    jt_reset = 1'b0;
    tick(30);
    n_checks++; if (got_d2h.size() - b !== 2) $display("FAIL rst_nonce_abandon: got %0d words expected 2", got_d2h.size() - b); else n_pass++;
  endtask

  task automatic test_random_loads();
    logic [8:0]   words [$];
    logic [351:0] exp_c [$];
    int wb, m;
    wb = got_work.size();
    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(0, 3))
        0: begin
          words.push_back(9'h101);
          for (int j = 0; j < 44; j++) words.push_back(9'($urandom_range(0, 255)));
        end
        1: begin
          words.push_back(9'h101);
          m = $urandom_range(1, 43);
          for (int j = 0; j < m; j++) words.push_back(9'($urandom_range(0, 255)));
        end
        2: for (int j = 0; j < $urandom_range(1, 5); j++) words.push_back(9'($urandom_range(0, 255)));
        default: begin
          words.push_back(9'h100 | 9'($urandom_range(4, 255)));
          words.push_back(9'($urandom_range(0, 255)));
        end
      endcase
    end
    model_loads(words, exp_c);
    foreach (words[i]) h2d_q.push_back(words[i]);
    for (int c = 0; c < 2 * words.size() + 100 && h2d_q.size() != 0; c++) tick(1);
    tick(10);
    n_checks++; if (got_work.size() - wb !== exp_c.size()) $display("FAIL rnd_commit_count: got %0d expected %0d", got_work.size() - wb, exp_c.size()); else n_pass++;
    foreach (exp_c[i]) if (got_work.size() > wb + i) begin
      n_checks++; if (got_work[wb+i] !== exp_c[i]) $display("FAIL rnd_commit%0d: got %h expected %h", i, got_work[wb+i], exp_c[i]); else n_pass++;
    end
  endtask

  task automatic test_random_nonces();
    logic [11:0] exp [$];
    logic [31:0] n;
    int b, wv0, burst;
    wv0 = wr_viol;
    for (int r = 0; r < 3; r++) begin
      b = got_d2h.size();
      exp = {};
      burst = $urandom_range(1, 4);
      for (int i = 0; i < burst; i++) begin
        n = $urandom;
        for (int j = 0; j < 4; j++) exp.push_back(nonce_word(n, j));
        bus.golden_nonce = n;
        bus.golden_nonce_valid = 1'b1;
        tick(1);
      end
      bus.golden_nonce_valid = 1'b0;
      for (int c = 0; c < 400 && got_d2h.size() < b + exp.size(); c++) begin
        bus.d2h_full = ($urandom_range(0, 2) == 0);
        tick(1);
      end
      bus.d2h_full = 1'b0;
      tick(10);
      n_checks++; if (got_d2h.size() - b !== exp.size()) $display("FAIL rnd_nonce_count%0d: got %0d expected %0d", r, got_d2h.size() - b, exp.size()); else n_pass++;
      foreach (exp[i]) if (got_d2h.size() > b + i) begin
        n_checks++; if (got_d2h[b+i] !== exp[i]) $display("FAIL rnd_nonce%0d_w%0d: got %h expected %h", r, i, got_d2h[b+i], exp[i]); else n_pass++;
      end
    end
    n_checks++; if (wr_viol - wv0 !== 0) $display("FAIL rnd_wr_while_full: got %0d expected 0", wr_viol - wv0); else n_pass++;
  endtask

  initial begin
    bus.d2h_full           = 1'b0;
    bus.golden_nonce       = 32'h0;
    bus.golden_nonce_valid = 1'b0;
    tick(2);
    test_reset();
    test_load_commit();
    test_abort_status();
    test_nonce_stream();
    test_backpressure();
    test_overflow_flush();
    test_reset_midway();
    test_random_loads();
    test_random_nonces();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
